image_pixel_streamer: RTL and testbench

Parametrised successor to the image-to-LED shifter. Captures a full flattened image in one load handshake, then streams it out pixel by pixel over a valid/ready interface, with a pixel index, a last flag and a selectable one-shot or wrap-around mode. It also mirrors the most recently accepted pixel onto the board LEDs. Sits between the image source (UART/ROM loader) and the display/debug path.

---
 rtl/image_pixel_streamer.sv | 165 ++++++++++++++++
 tb/tb_image_pixel_streamer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/image_pixel_streamer.sv
// Captures a flattened image in one load handshake and streams it out pixel by pixel.
// Optional checksum outputs are enabled by defining IMG_STREAM_CHECKSUM_EN.
module image_pixel_streamer #(
  parameter int N_PIX = 784,
  parameter int PIX_W = 8,
  parameter int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1,
  parameter int LED_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [N_PIX*PIX_W-1:0] image,
  input  logic                   wrap,
  input  logic                   abort,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [PIX_W-1:0]       pix_data,
  output logic [IDX_W-1:0]       pix_idx,
  output logic                   pix_last,
  output logic                   done,
  output logic [LED_W-1:0]       LEDS
`ifdef IMG_STREAM_CHECKSUM_EN
  ,
  output logic [PIX_W+IDX_W-1:0] checksum,
  output logic                   checksum_valid
`endif
);

  // Handshakes: a transfer happens on an edge where valid && ready are both high;
  // a producer holds valid and its data steady until that edge.

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [PIX_W-1:0] r_buf [N_PIX];
  logic [IDX_W-1:0] r_idx;
  logic             r_wrap;
  logic             r_done;
  logic [LED_W-1:0] r_leds;
  logic             w_load;
  logic             w_xfer;
  logic             w_abort;
  logic             w_last;
  logic [LED_W-1:0] w_led_val;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_xfer       = 1'b0;
    w_abort      = 1'b0;
    load_ready   = 1'b0;
    pix_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_load       = 1'b1;
          w_next_state = S_STREAM;
        end
      end
      S_STREAM: begin
        pix_valid = 1'b1;
        // abort discards any transfer offered on the same edge
        if (abort) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else if (pix_ready) begin
          w_xfer = 1'b1;
          if (w_last && !r_wrap) w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_last   = (r_idx == LAST_IDX);
  assign pix_last = pix_valid && w_last;
  assign pix_data = pix_valid ? r_buf[r_idx] : '0;
  assign pix_idx  = r_idx;
  assign done     = r_done;
  assign LEDS     = r_leds;

  generate
    if (PIX_W >= LED_W) begin : g_led_trunc
      assign w_led_val = pix_data[LED_W-1:0];
    end else begin : g_led_ext
      assign w_led_val = {{(LED_W-PIX_W){1'b0}}, pix_data};
    end
  endgenerate

  // Image storage needs no reset; it is only read while streaming a loaded image.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int i = 0; i < N_PIX; i++) r_buf[i] <= image[i*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      r_leds <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_idx  <= '0;
        r_wrap <= wrap;
      end else if (w_abort) begin
        r_idx <= '0;
      end else if (w_xfer) begin
        r_leds <= w_led_val;
        if (w_last) begin
          r_idx  <= '0;
          r_done <= !r_wrap;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

`ifdef IMG_STREAM_CHECKSUM_EN
  localparam int CS_W = PIX_W + IDX_W;

  logic [CS_W-1:0] r_checksum;
  logic            r_cs_valid;
  logic            r_cs_clear;
  logic [CS_W-1:0] w_cs_base;

  // After a wrap the published sum stays visible until the next pixel restarts it.
  assign w_cs_base = r_cs_clear ? '0 : r_checksum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_checksum <= '0;
      r_cs_valid <= 1'b0;
      r_cs_clear <= 1'b0;
    end else begin
      r_cs_valid <= 1'b0;
      if (w_load) begin
        r_checksum <= '0;
        r_cs_clear <= 1'b0;
      end else if (w_xfer) begin
        r_checksum <= w_cs_base + CS_W'(pix_data);
        r_cs_valid <= w_last;
        r_cs_clear <= w_last;
      end
    end
  end

  assign checksum       = r_checksum;
  assign checksum_valid = r_cs_valid;
`endif

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Directed, table-driven bench for image_pixel_streamer (N_PIX=4, PIX_W=8).
// Checksum comparisons are active when IMG_STREAM_CHECKSUM_EN is defined.
module tb_image_pixel_streamer;

  localparam int N_PIX = 4;
  localparam int PIX_W = 8;
  localparam int IDX_W = 2;
  localparam int LED_W = 8;
  localparam int NVEC  = 31;

  logic                   clk;
  logic                   rst_n;
  logic                   load_valid;
  logic                   load_ready;
  logic [N_PIX*PIX_W-1:0] image;
  logic                   wrap;
  logic                   abort;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [PIX_W-1:0]       pix_data;
  logic [IDX_W-1:0]       pix_idx;
  logic                   pix_last;
  logic                   done;
  logic [LED_W-1:0]       LEDS;
`ifdef IMG_STREAM_CHECKSUM_EN
  logic [PIX_W+IDX_W-1:0] checksum;
  logic                   checksum_valid;
`endif

  int checks = 0;
  int errors = 0;

  image_pixel_streamer #(
    .N_PIX(N_PIX), .PIX_W(PIX_W), .IDX_W(IDX_W), .LED_W(LED_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .image(image),
    .wrap(wrap), .abort(abort),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_idx(pix_idx), .pix_last(pix_last), .done(done), .LEDS(LEDS)
`ifdef IMG_STREAM_CHECKSUM_EN
    , .checksum(checksum), .checksum_valid(checksum_valid)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in = {load_valid, wrap, abort, pix_ready}; fl = {load_ready, pix_valid, pix_last, done, cs_valid}
  typedef struct {
    logic [3:0] in;
    logic [4:0] fl;
    logic [7:0] data;
    logic [1:0] idx;
    logic [7:0] leds;
    logic [9:0] cs;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [3:0] in, input logic [4:0] fl, input logic [7:0] data,
                              input logic [1:0] idx, input logic [7:0] leds, input logic [9:0] cs);
    vec_t v;
    v.in = in; v.fl = fl; v.data = data; v.idx = idx; v.leds = leds; v.cs = cs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic lr, input logic pv, input logic [7:0] data,
                         input logic [1:0] idx, input logic last, input logic dn, input logic [7:0] leds,
                         input logic [9:0] cs, input logic csv);
    chk({tag, ".load_ready"}, 32'(load_ready), 32'(lr));
    chk({tag, ".pix_valid"},  32'(pix_valid),  32'(pv));
    chk({tag, ".pix_data"},   32'(pix_data),   32'(data));
    chk({tag, ".pix_idx"},    32'(pix_idx),    32'(idx));
    chk({tag, ".pix_last"},   32'(pix_last),   32'(last));
    chk({tag, ".done"},       32'(done),       32'(dn));
    chk({tag, ".LEDS"},       32'(LEDS),       32'(leds));
`ifdef IMG_STREAM_CHECKSUM_EN
    chk({tag, ".checksum"},       32'(checksum),       32'(cs));
    chk({tag, ".checksum_valid"}, 32'(checksum_valid), 32'(csv));
`else
    if (cs != cs || csv != csv) $display("unreachable");
`endif
  endtask

  task automatic drive(input logic [3:0] in);
    {load_valid, wrap, abort, pix_ready} = in;
  endtask

  initial begin
    // one-shot, free-running consumer
    vecs[0]  = mk(4'b1001, 5'b01000, 8'h11, 2'd0, 8'h00, 10'h000);
    vecs[1]  = mk(4'b0001, 5'b01000, 8'h22, 2'd1, 8'h11, 10'h011);
    vecs[2]  = mk(4'b0001, 5'b01000, 8'h33, 2'd2, 8'h22, 10'h033);
    vecs[3]  = mk(4'b0001, 5'b01100, 8'h44, 2'd3, 8'h33, 10'h066);
    vecs[4]  = mk(4'b0001, 5'b10011, 8'h00, 2'd0, 8'h44, 10'h0AA);
    vecs[5]  = mk(4'b0000, 5'b10000, 8'h00, 2'd0, 8'h44, 10'h0AA);
    // one-shot with stalls
    vecs[6]  = mk(4'b1000, 5'b01000, 8'h11, 2'd0, 8'h44, 10'h000);
    vecs[7]  = mk(4'b0001, 5'b01000, 8'h22, 2'd1, 8'h11, 10'h011);
    vecs[8]  = mk(4'b0000, 5'b01000, 8'h22, 2'd1, 8'h11, 10'h011);
    vecs[9]  = mk(4'b0000, 5'b01000, 8'h22, 2'd1, 8'h11, 10'h011);
    vecs[10] = mk(4'b0001, 5'b01000, 8'h33, 2'd2, 8'h22, 10'h033);
    vecs[11] = mk(4'b0001, 5'b01100, 8'h44, 2'd3, 8'h33, 10'h066);
    vecs[12] = mk(4'b0000, 5'b01100, 8'h44, 2'd3, 8'h33, 10'h066);
    vecs[13] = mk(4'b0001, 5'b10011, 8'h00, 2'd0, 8'h44, 10'h0AA);
    // wrap mode; load_valid held high and wrap dropped mid-stream are both ignored
    vecs[14] = mk(4'b1101, 5'b01000, 8'h11, 2'd0, 8'h44, 10'h000);
    vecs[15] = mk(4'b1001, 5'b01000, 8'h22, 2'd1, 8'h11, 10'h011);
    vecs[16] = mk(4'b1001, 5'b01000, 8'h33, 2'd2, 8'h22, 10'h033);
    vecs[17] = mk(4'b1001, 5'b01100, 8'h44, 2'd3, 8'h33, 10'h066);
    vecs[18] = mk(4'b1001, 5'b01001, 8'h11, 2'd0, 8'h44, 10'h0AA);
    vecs[19] = mk(4'b1001, 5'b01000, 8'h22, 2'd1, 8'h11, 10'h011);
    vecs[20] = mk(4'b1001, 5'b01000, 8'h33, 2'd2, 8'h22, 10'h033);
    vecs[21] = mk(4'b1001, 5'b01100, 8'h44, 2'd3, 8'h33, 10'h066);
    vecs[22] = mk(4'b1001, 5'b01001, 8'h11, 2'd0, 8'h44, 10'h0AA);
    vecs[23] = mk(4'b1001, 5'b01000, 8'h22, 2'd1, 8'h11, 10'h011);
    vecs[24] = mk(4'b0001, 5'b01000, 8'h33, 2'd2, 8'h22, 10'h033);
    // abort at idx 2 beats the transfer; then abort in IDLE with a load
    vecs[25] = mk(4'b0011, 5'b10000, 8'h00, 2'd0, 8'h22, 10'h033);
    vecs[26] = mk(4'b0000, 5'b10000, 8'h00, 2'd0, 8'h22, 10'h033);
    vecs[27] = mk(4'b1010, 5'b01000, 8'h11, 2'd0, 8'h22, 10'h000);
    vecs[28] = mk(4'b0001, 5'b01000, 8'h22, 2'd1, 8'h11, 10'h011);
    vecs[29] = mk(4'b0001, 5'b01000, 8'h33, 2'd2, 8'h22, 10'h033);
    vecs[30] = mk(4'b0001, 5'b01100, 8'h44, 2'd3, 8'h33, 10'h066);

    image = 32'h44332211;
    drive(4'b1001);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0);
    drive(4'b0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("idle", 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].in);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].fl[4], vecs[i].fl[3], vecs[i].data, vecs[i].idx,
              vecs[i].fl[2], vecs[i].fl[1], vecs[i].leds, vecs[i].cs, vecs[i].fl[0]);
    end

    // reset glitch between edges is not sampled; stream sits stalled at idx 3
    drive(4'b0000);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("glitch", 1'b0, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0, 8'h33, 10'h066, 1'b0);

    // synchronous reset mid-stream, with a transfer offered on the same edge
    drive(4'b0001);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all("midrst", 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0);
    rst_n = 1'b1;

    // fresh one-shot load after reset reaches done
    drive(4'b1001);
    @(posedge clk);
    #1;
    chk_all("reload", 1'b0, 1'b1, 8'h11, 2'd0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0);
    drive(4'b0001);
    repeat (4) @(posedge clk);
    #1;
    chk_all("redone", 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 8'h44, 10'h0AA, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
